// File: rtl/mux64_4_arb_if.sv
// mux64_4_arb_if: bundle of the requester, grant and output-register signals
// of the 4-way round-robin arbitrating mux.
//   req      4   requester k offers y<k> while req[k] is high
//   y0..y3   W   requester data words
//   gnt      4   one-hot or zero grant (combinational in the arbiter)
//   x        2   index of the requester whose word is on z
//   z        W   selected data word
//   z_valid  1   z/x hold an unconsumed word
//   z_ready  1   consumer accepts z when z_valid && z_ready
// master: requesters + consumer side; slave: the arbiter.
interface mux64_4_arb_if #(
    parameter int unsigned W = 64
);
    logic [3:0]   req;
    logic [W-1:0] y0;
    logic [W-1:0] y1;
    logic [W-1:0] y2;
    logic [W-1:0] y3;
    logic [3:0]   gnt;
    logic [1:0]   x;
    logic [W-1:0] z;
    logic         z_valid;
    logic         z_ready;

    modport master (
        output req, y0, y1, y2, y3, z_ready,
        input  gnt, x, z, z_valid
    );

    modport slave (
        input  req, y0, y1, y2, y3, z_ready,
        output gnt, x, z, z_valid
    );
endinterface

// File: rtl/mux64_4_arb.sv
// mux64_4_arb: round-robin arbiter over four W-bit requesters feeding a
// single-entry registered output slot.
//   clk  1   clock, all state changes on the rising edge
//   rst  1   asynchronous active-high reset
//   bus  mux64_4_arb_if.slave
//        gnt is combinational from req, last, z_valid, z_ready and rst;
//        z, x, z_valid are registered.
module mux64_4_arb #(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst,
    mux64_4_arb_if.slave bus
);
    localparam int unsigned NREQ = 4;
    localparam int unsigned IDXW = 2;

    logic [IDXW-1:0] last_q;
    logic [IDXW-1:0] last_d;
    logic [IDXW-1:0] x_q;
    logic [IDXW-1:0] x_d;
    logic [W-1:0]    z_q;
    logic [W-1:0]    z_d;
    logic            z_valid_q;
    logic            z_valid_d;

    logic            slot_free;
    logic            gnt_any;
    logic [IDXW-1:0] gnt_idx;
    logic [IDXW-1:0] scan_idx;
    logic [NREQ-1:0] gnt;
    logic [W-1:0]    y_sel;

    // Slot can take a word when empty or being drained this cycle.
    assign slot_free = ~z_valid_q | bus.z_ready;

    // Round-robin scan starting just after the last grant; the 2-bit add
    // wraps naturally so indices last+1..last+4 cover every requester once.
    // Grant is forced off during reset so nothing is offered while held.
    always_comb begin : arb
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        gnt      = '0;
        if (!rst && slot_free) begin
            for (int unsigned i = 1; i <= NREQ; i++) begin
                scan_idx = last_q + IDXW'(i);
                if (!gnt_any && bus.req[scan_idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = scan_idx;
                end
            end
        end
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    // Data select, only the datapath depends on y0..y3.
    always_comb begin : data_mux
        y_sel = '0;
        case (gnt_idx)
            2'd0:    y_sel = bus.y0;
            2'd1:    y_sel = bus.y1;
            2'd2:    y_sel = bus.y2;
            default: y_sel = bus.y3;
        endcase
    end

    // Slot next state: load on grant (also covers consume+grant with no
    // bubble), drain on consume without grant, otherwise hold.
    always_comb begin : slot_next
        last_d    = last_q;
        x_d       = x_q;
        z_d       = z_q;
        z_valid_d = z_valid_q;
        if (gnt_any) begin
            last_d    = gnt_idx;
            x_d       = gnt_idx;
            z_d       = y_sel;
            z_valid_d = 1'b1;
        end else if (z_valid_q && bus.z_ready) begin
            z_valid_d = 1'b0;
        end
    end

    // Reset parks the pointer at 3 so the first scan starts at index 0.
    always_ff @(posedge clk or posedge rst) begin : slot_reg
        if (rst) begin
            last_q    <= 2'b11;
            x_q       <= '0;
            z_q       <= '0;
            z_valid_q <= 1'b0;
        end else begin
            last_q    <= last_d;
            x_q       <= x_d;
            z_q       <= z_d;
            z_valid_q <= z_valid_d;
        end
    end

    assign bus.gnt     = gnt;
    assign bus.x       = x_q;
    assign bus.z       = z_q;
    assign bus.z_valid = z_valid_q;
endmodule

// File: doc/mux64_4_arb.md
MUX64_4_ARB -- requirements
Module: mux64_4_arb

Interface
REQ-001 The block SHALL have one parameter: W, default 64, data width of each requester and of the output.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port req, input, 4 bits: req[k] high means requester k offers y<k>.
REQ-005 The block SHALL have ports y0, y1, y2 and y3, input, W bits each: requester data words.
REQ-006 The block SHALL have port gnt, output, 4 bits: one-hot or zero, combinational; gnt[k] high means y<k> is captured at the next rising edge.
REQ-007 The block SHALL have port x, output, 2 bits: registered index of the requester whose word is on z.
REQ-008 The block SHALL have port z, output, W bits: registered selected data word.
REQ-009 The block SHALL have port z_valid, output, 1 bit: z and x hold an unconsumed word.
REQ-010 The block SHALL have port z_ready, input, 1 bit: the consumer accepts z in any cycle where z_valid and z_ready are both high.

Function
REQ-011 The block SHALL hold a single-entry output register (z, x, z_valid) and a 2-bit round-robin pointer last, the index of the most recent grant.
REQ-012 The slot SHALL be free in a cycle when z_valid==0 or z_ready==1.
REQ-013 When the slot is free and req!=0, gnt SHALL select the first set req bit scanning last+1, last+2, last+3, last+4, each taken mod 4; otherwise gnt SHALL be 4'b0000.
REQ-014 On a rising edge with gnt[k]==1, the block SHALL load z<=y<k>, x<=k, z_valid<=1 and last<=k.
REQ-015 On a rising edge with gnt==0, z_valid==1 and z_ready==1, the block SHALL clear z_valid and leave z, x and last unchanged.
REQ-016 On a rising edge with z_valid==1 and z_ready==0 (backpressure), z, x, z_valid and last SHALL hold, and gnt SHALL be 0 in that cycle.
REQ-017 Latency SHALL be 1 cycle from the granting edge to z_valid; throughput SHALL be 1 word per cycle when z_ready is held high.
REQ-018 Simultaneous consume and grant SHALL be supported: z_valid stays 1 and the new word replaces the old word on that edge, with no bubble.
REQ-019 The pointer SHALL wrap from 3 to 0, with no skipped or repeated index.
REQ-020 A requester holding req high SHALL be granted within at most 4 grants (no starvation).
REQ-021 Requesters SHALL keep req and y<k> stable until they see gnt[k]; a req deasserted before its grant is simply not served, with no error state.
REQ-022 The gnt path SHALL depend only on req, last, z_valid and z_ready, not on y0..y3.

Reset
REQ-023 While rst is high, z SHALL be 0, x SHALL be 2'b00, z_valid SHALL be 0, last SHALL be 2'b11 and gnt SHALL be 4'b0000, regardless of the clock.
REQ-024 Assertion of rst mid-transfer SHALL discard the held word immediately; the first grant after release SHALL go to the lowest-index active requester starting from index 0.
REQ-025 After rst deasserts, the first rising edge SHALL already be able to grant.

Verification
REQ-026 Reset then req=4'b0001, y0=64'hAAAA_AAAA_AAAA_AAAA, z_ready=1 -> gnt=4'b0001, then next cycle z=64'hAAAA_AAAA_AAAA_AAAA, x=0, z_valid=1.
REQ-027 req=4'b1111 held, z_ready=1 constantly, y0..y3 = 64'hAAAA..AA, 64'h5555..55, 64'hCCCC..CC, 64'h3333..33 -> x sequence 0,1,2,3,0 on consecutive cycles, z matching each word, z_valid continuously 1.
REQ-028 z_valid=1 with x=2, z_ready=0 for 3 cycles, req=4'b1011 -> gnt=0 throughout, z and x stable; then z_ready=1 -> next grant is requester 3, then 0.
REQ-029 req=4'b0000, z_valid=1, z_ready=1 -> z_valid drops to 0 on the next edge and z retains its last value.
REQ-030 rst pulsed asynchronously between edges while z_valid=1 and last=1 -> outputs clear immediately; after release with req=4'b0110, first grant goes to requester 1.
REQ-031 Random req, z_ready and data over 10,000 cycles -> scoreboard confirms no lost or duplicated words, gnt always one-hot or zero, and every waiting requester served within 4 grants.
